// File: rtl/speech_buf_pkg.sv
// speech_buf_pkg: default ring-buffer constants plus sign-extension and window-wrap helpers
package speech_buf_pkg;

    localparam int BUF_BASE  = 160;
    localparam int BUF_DEPTH = 80;
    localparam int FRAME_LEN = 40;
    localparam int OVR_SEL   = 48;

    // Sign-extends the low w bits of s to 64 bits; callers truncate to their word width.
    function automatic logic [63:0] sext_sample(input logic [63:0] s, input int unsigned w);
        return 64'($signed(s << (64 - w)) >>> (64 - w));
    endfunction

    // base_addr+offset folded back into [win_base, win_base+depth); offset must be < depth.
    function automatic int unsigned ring_wrap(input int unsigned base_addr, input int unsigned offset,
                                              input int unsigned win_base, input int unsigned depth);
        int unsigned s;
        s = base_addr + offset;
        return (s >= win_base + depth) ? s - depth : s;
    endfunction

endpackage

// File: rtl/speech_dpram.sv
// speech_dpram: simple dual-port RAM, one write port, one registered read-first read port
//  clk_i            clock
//  we_i/waddr_i/wdata_i   write port
//  re_i/raddr_i     read request; rdata_o valid the cycle after, holds when re_i is low
module speech_dpram #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] rdata_q;

    // Both updates in one block: a same-address read sees the pre-write word.
    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/speech_ring_buf_ctrl.sv
// speech_ring_buf_ctrl: circular speech buffer controller with frame tracking and relative reads
//  clock_i           clock; reset_i synchronous active-low
//  in_done_i/in_sample_i     sample strobe and data, written sign-extended into the ring window
//  math_mux_sel_i    == OVR_SEL hands the write port to mem_write_addr_i/mem_in_i/mem_write_en_i
//  rd_rel_i/rd_addr_i        read address (physical, or offset from frame_start_o)
//  out_sample_o      read data, one cycle latency
//  frame_done_o      pulse after the last sample of a frame; frame_start_o = its first address
//  sample_dropped_o  pulse after an in_done_i swallowed by an override cycle
//  OVERRUN_DETECT_EN adds frame_ack_i, ovr_clr_i and sticky overrun_o
module speech_ring_buf_ctrl #(
    parameter int SAMPLE_W  = 16,
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int BUF_BASE  = speech_buf_pkg::BUF_BASE,
    parameter int BUF_DEPTH = speech_buf_pkg::BUF_DEPTH,
    parameter int FRAME_LEN = speech_buf_pkg::FRAME_LEN,
    parameter int SEL_W     = 6,
    parameter int OVR_SEL   = speech_buf_pkg::OVR_SEL
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                in_done_i,
    input  logic [SAMPLE_W-1:0] in_sample_i,
    input  logic [SEL_W-1:0]    math_mux_sel_i,
    input  logic [ADDR_W-1:0]   mem_write_addr_i,
    input  logic [WORD_W-1:0]   mem_in_i,
    input  logic                mem_write_en_i,
    input  logic                rd_rel_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
`ifdef OVERRUN_DETECT_EN
    input  logic                frame_ack_i,
    input  logic                ovr_clr_i,
    output logic                overrun_o,
`endif
    output logic [WORD_W-1:0]   out_sample_o,
    output logic                frame_done_o,
    output logic [ADDR_W-1:0]   frame_start_o,
    output logic                sample_dropped_o
);

    import speech_buf_pkg::*;

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [ADDR_W:0] WIN_END = (ADDR_W+1)'(BUF_BASE + BUF_DEPTH);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(BUF_DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, frame_start_q, frame_start_d;
    logic [CNT_W-1:0]  samp_cnt_q, samp_cnt_d;
    logic              frame_done_q, sample_dropped_q, zero_q;
    logic              ovr, accept, last, fin, rd_oob, we;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [WORD_W-1:0] wdata, rdata;
    logic [ADDR_W:0]   rel_sum, rel_phys;

    assign ovr    = math_mux_sel_i == SEL_W'(OVR_SEL);
    assign accept = in_done_i && !ovr;
    assign last   = samp_cnt_q == CNT_W'(FRAME_LEN - 1);
    assign fin    = accept && last;

    assign we    = ovr ? mem_write_en_i : accept;
    assign waddr = ovr ? mem_write_addr_i : wr_ptr_q;
    assign wdata = ovr ? mem_in_i : WORD_W'(sext_sample(64'(in_sample_i), SAMPLE_W));

    // One extra bit so frame_start+offset cannot overflow before the window-end compare.
    assign rel_sum  = {1'b0, frame_start_q} + {1'b0, rd_addr_i};
    assign rel_phys = (rel_sum >= WIN_END) ? rel_sum - DEPTH_X : rel_sum;
    assign raddr    = rd_rel_i ? ADDR_W'(rel_phys) : rd_addr_i;
    assign rd_oob   = rd_rel_i && ({1'b0, rd_addr_i} >= DEPTH_X);

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        samp_cnt_d    = samp_cnt_q;
        frame_start_d = frame_start_q;
        if (accept) begin
            wr_ptr_d   = (wr_ptr_q == ADDR_W'(BUF_BASE + BUF_DEPTH - 1)) ? ADDR_W'(BUF_BASE) : wr_ptr_q + ADDR_W'(1);
            samp_cnt_d = last ? '0 : samp_cnt_q + CNT_W'(1);
            // Stepping forward by DEPTH-(LEN-1) inside the window equals stepping back LEN-1.
            if (last) frame_start_d = ADDR_W'(ring_wrap(32'(wr_ptr_q), BUF_DEPTH - (FRAME_LEN - 1), BUF_BASE, BUF_DEPTH));
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            wr_ptr_q         <= ADDR_W'(BUF_BASE);
            samp_cnt_q       <= '0;
            frame_start_q    <= ADDR_W'(BUF_BASE);
            frame_done_q     <= 1'b0;
            sample_dropped_q <= 1'b0;
            zero_q           <= 1'b1;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            samp_cnt_q       <= samp_cnt_d;
            frame_start_q    <= frame_start_d;
            frame_done_q     <= fin;
            sample_dropped_q <= in_done_i && ovr;
            zero_q           <= rd_oob;
        end
    end

`ifdef OVERRUN_DETECT_EN
    logic pending_q, overrun_q;
    // A new overrun event takes priority over a coincident clear so it is never lost.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= fin ? 1'b1 : (frame_ack_i ? 1'b0 : pending_q);
            overrun_q <= (fin && pending_q && !frame_ack_i) ? 1'b1 : (ovr_clr_i ? 1'b0 : overrun_q);
        end
    end
    assign overrun_o = overrun_q;
`endif

    speech_dpram #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_ram (
        .clk_i   (clock_i),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .re_i    (!rd_oob),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign out_sample_o     = zero_q ? '0 : rdata;
    assign frame_done_o     = frame_done_q;
    assign frame_start_o    = frame_start_q;
    assign sample_dropped_o = sample_dropped_q;

endmodule

// File: tb/tb_speech_ring_buf_ctrl.sv
// tb_speech_ring_buf_ctrl: directed stimulus with a cycle-stamped scoreboard and decoupled monitor
module tb_speech_ring_buf_ctrl;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        in_done_i = 1'b0;
    logic [15:0] in_sample_i = '0;
    logic [5:0]  math_mux_sel_i = '0;
    logic [7:0]  mem_write_addr_i = '0;
    logic [31:0] mem_in_i = '0;
    logic        mem_write_en_i = 1'b0;
    logic        rd_rel_i = 1'b0;
    logic [7:0]  rd_addr_i = '0;
    logic [31:0] out_sample_o;
    logic        frame_done_o;
    logic [7:0]  frame_start_o;
    logic        sample_dropped_o;
`ifdef OVERRUN_DETECT_EN
    logic        frame_ack_i = 1'b0;
    logic        ovr_clr_i = 1'b0;
    logic        overrun_o;
`endif

    speech_ring_buf_ctrl dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .in_done_i        (in_done_i),
        .in_sample_i      (in_sample_i),
        .math_mux_sel_i   (math_mux_sel_i),
        .mem_write_addr_i (mem_write_addr_i),
        .mem_in_i         (mem_in_i),
        .mem_write_en_i   (mem_write_en_i),
        .rd_rel_i         (rd_rel_i),
        .rd_addr_i        (rd_addr_i),
`ifdef OVERRUN_DETECT_EN
        .frame_ack_i      (frame_ack_i),
        .ovr_clr_i        (ovr_clr_i),
        .overrun_o        (overrun_o),
`endif
        .out_sample_o     (out_sample_o),
        .frame_done_o     (frame_done_o),
        .frame_start_o    (frame_start_o),
        .sample_dropped_o (sample_dropped_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t       chk_q[$];
    int         fd_cyc_q[$];
    logic [7:0] fd_fs_q[$];
    int         dr_q[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    always @(posedge clock_i) cyc <= cyc + 1;

    always @(negedge clock_i) begin
        logic [31:0] act;
        string       nm;
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            chk_t c;
            c = chk_q.pop_front();
            nm = c.kind == 0 ? "out_sample" : c.kind == 1 ? "frame_start" : "overrun";
            act = c.kind == 0 ? out_sample_o : c.kind == 1 ? 32'(frame_start_o) : 32'h0;
`ifdef OVERRUN_DETECT_EN
            if (c.kind == 2) act = 32'(overrun_o);
`endif
            n_chk++;
            if (c.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s stale check for cycle %0d at cycle %0d", nm, c.cyc, cyc);
            end else if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, c.exp);
            end
        end
        if (fd_cyc_q.size() > 0 && fd_cyc_q[0] < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_done missing: expected at cycle %0d, now %0d", fd_cyc_q.pop_front(), cyc);
            void'(fd_fs_q.pop_front());
        end
        if (frame_done_o === 1'b1) begin
            n_chk++;
            if (fd_cyc_q.size() == 0) begin
                n_fail++;
                $display("FAIL frame_done unexpected at cycle %0d (frame_start %0d)", cyc, frame_start_o);
            end else begin
                int         ec;
                logic [7:0] ef;
                ec = fd_cyc_q.pop_front();
                ef = fd_fs_q.pop_front();
                if (ec != cyc || frame_start_o !== ef) begin
                    n_fail++;
                    $display("FAIL frame_done: got cycle %0d start %0d expected cycle %0d start %0d", cyc, frame_start_o, ec, ef);
                end
            end
        end
        if (dr_q.size() > 0 && dr_q[0] < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL sample_dropped missing: expected at cycle %0d, now %0d", dr_q.pop_front(), cyc);
        end
        if (sample_dropped_o === 1'b1) begin
            n_chk++;
            if (dr_q.size() == 0 || dr_q[0] != cyc) begin
                n_fail++;
                $display("FAIL sample_dropped unexpected pulse at cycle %0d", cyc);
            end else void'(dr_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        in_done_i = 1'b0;
        chk_q.push_back('{cyc + 1, 1, 32'd160});
        chk_q.push_back('{cyc + 1, 0, 32'd0});
        tick();
        reset_i = 1'b1;
    endtask

    task automatic strobe(input logic [15:0] s, input bit fd, input logic [7:0] fs);
        in_done_i = 1'b1;
        in_sample_i = s;
        if (fd) begin
            fd_cyc_q.push_back(cyc + 1);
            fd_fs_q.push_back(fs);
        end
        tick();
        in_done_i = 1'b0;
    endtask

    task automatic rd(input bit rel, input logic [7:0] a, input logic [31:0] e);
        rd_rel_i = rel;
        rd_addr_i = a;
        chk_q.push_back('{cyc + 1, 0, e});
        tick();
    endtask

    initial begin
        tick();
        do_reset();
        // 1: one full frame, then relative reads of every sample
        for (int i = 0; i < 40; i++) strobe(16'(i + 1), i == 39, 8'd160);
        chk_q.push_back('{cyc, 1, 32'd160});
        for (int i = 0; i < 40; i++) rd(1'b1, 8'(i), 32'(i + 1));
        // 2: sign extension, written at 200..202
        strobe(16'h8000, 1'b0, 8'd0);
        strobe(16'hFFFF, 1'b0, 8'd0);
        strobe(16'h7FFF, 1'b0, 8'd0);
        rd(1'b0, 8'd200, 32'hFFFF8000);
        rd(1'b0, 8'd201, 32'hFFFFFFFF);
        rd(1'b0, 8'd202, 32'h00007FFF);
        // 3: 100 strobes wrap 239->160; samples 81..100 overwrite 160..179
        do_reset();
        for (int i = 0; i < 100; i++) strobe(16'(i + 1), i == 39 || i == 79, i == 39 ? 8'd160 : 8'd200);
        chk_q.push_back('{cyc, 1, 32'd200});
        rd(1'b0, 8'd160, 32'd81);
        rd(1'b0, 8'd165, 32'd86);
        rd(1'b1, 8'd45, 32'd86);
        rd(1'b0, 8'd239, 32'd80);
        rd(1'b0, 8'd180, 32'd21);
        // 4: override write while a strobe arrives; the strobe is dropped, wr_ptr stays at 180
        math_mux_sel_i = 6'd48;
        mem_write_en_i = 1'b1;
        mem_write_addr_i = 8'd10;
        mem_in_i = 32'hDEADBEEF;
        in_done_i = 1'b1;
        in_sample_i = 16'h1234;
        dr_q.push_back(cyc + 1);
        tick();
        in_done_i = 1'b0;
        mem_write_en_i = 1'b0;
        math_mux_sel_i = 6'd0;
        rd(1'b0, 8'd10, 32'hDEADBEEF);
        rd(1'b0, 8'd180, 32'd21);
        // read-first: read 180 in the same cycle the next sample lands there
        rd_rel_i = 1'b0;
        rd_addr_i = 8'd180;
        chk_q.push_back('{cyc + 1, 0, 32'd21});
        for (int i = 0; i < 20; i++) strobe(16'(16'h100 + i), i == 19, 8'd160);
        rd(1'b0, 8'd180, 32'h100);
        rd(1'b0, 8'd199, 32'h113);
        // 5: reset mid-frame discards the partial frame
        do_reset();
        for (int i = 0; i < 25; i++) strobe(16'(16'h300 + i), 1'b0, 8'd0);
        do_reset();
        for (int i = 0; i < 40; i++) strobe(16'(16'h200 + i), i == 39, 8'd160);
        rd(1'b1, 8'd0, 32'h200);
        rd(1'b1, 8'd80, 32'd0);
        rd(1'b1, 8'd39, 32'h227);
        rd(1'b1, 8'd255, 32'd0);
`ifdef OVERRUN_DETECT_EN
        // 6: pending/overrun behaviour
        do_reset();
        chk_q.push_back('{cyc, 2, 32'd0});
        for (int i = 0; i < 40; i++) strobe(16'(i), i == 39, 8'd160);
        chk_q.push_back('{cyc, 2, 32'd0});
        for (int i = 0; i < 40; i++) strobe(16'(i), i == 39, 8'd200);
        chk_q.push_back('{cyc, 2, 32'd1});
        ovr_clr_i = 1'b1;
        tick();
        ovr_clr_i = 1'b0;
        chk_q.push_back('{cyc, 2, 32'd0});
        for (int i = 0; i < 39; i++) strobe(16'(i), 1'b0, 8'd0);
        frame_ack_i = 1'b1;
        strobe(16'd39, 1'b1, 8'd160);
        frame_ack_i = 1'b0;
        chk_q.push_back('{cyc, 2, 32'd0});
        for (int i = 0; i < 40; i++) strobe(16'(i), i == 39, 8'd200);
        chk_q.push_back('{cyc, 2, 32'd1});
`endif
        repeat (3) tick();
        while (chk_q.size() > 0) begin
            chk_t c;
            c = chk_q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL check kind %0d never evaluated, due cycle %0d", c.kind, c.cyc);
        end
        while (fd_cyc_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_done never seen, due cycle %0d", fd_cyc_q.pop_front());
        end
        while (dr_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sample_dropped never seen, due cycle %0d", dr_q.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
